// File: rtl/countdown_hms.sv
// Loadable BCD HH:MM:SS kitchen-timer down-counter, rings when it reaches 00:00:00.
// Latency: every control input acts at the next CP edge; all outputs are registered.
// Backpressure: none; Tick pulses that arrive outside RUN/RING, or together with Stop, are dropped.
module countdown_hms #(
   parameter int HOUR_MAX   = 23,
   parameter int RING_TICKS = 10
) (
   input  logic       CP,
   input  logic       nCR,
   input  logic       Tick,
   input  logic       Load,
   input  logic [7:0] LdH,
   input  logic [7:0] LdM,
   input  logic [7:0] LdS,
   input  logic       Start,
   input  logic       Stop,
   output logic [7:0] CntH,
   output logic [7:0] CntM,
   output logic [7:0] CntS,
   output logic       Running,
   output logic       Done,
   output logic       Ring
);

   localparam int RW = $clog2(RING_TICKS + 1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_TICKS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_RING  = 2'd3
   } state_t;

   state_t        state;
   logic [RW-1:0] ring_cnt;

   logic [7:0] dec_h, dec_m, dec_s;
   logic       borrow_s, borrow_m;
   logic       count_zero, dec_zero;

   // Minutes/seconds field: invalid digits collapse the whole field to zero.
   function automatic logic [7:0] chk_ms(input logic [7:0] v);
      if (v[3:0] > 4'd9 || v[7:4] > 4'd5)
         return 8'h00;
      return v;
   endfunction

   // Hours field: valid BCD digits and a decimal value no larger than HOUR_MAX.
   function automatic logic [7:0] chk_h(input logic [7:0] v);
      int dec;
      if (v[3:0] > 4'd9 || v[7:4] > 4'd9)
         return 8'h00;
      dec = 10 * int'(v[7:4]) + int'(v[3:0]);
      if (dec > HOUR_MAX)
         return 8'h00;
      return v;
   endfunction

   // One BCD step down within a field; 00 is held (callers handle the wrap to 59).
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] != 4'd0)
         return {v[7:4], v[3:0] - 4'd1};
      if (v[7:4] != 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      return 8'h00;
   endfunction

   // Next count for a one-second decrement, borrowing seconds -> minutes -> hours.
   always_comb begin
      borrow_s = (CntS == 8'h00);
      borrow_m = borrow_s && (CntM == 8'h00);
      dec_s    = borrow_s ? 8'h59 : bcd_dec(CntS);
      dec_m    = CntM;
      if (borrow_s)
         dec_m = borrow_m ? 8'h59 : bcd_dec(CntM);
      dec_h    = borrow_m ? bcd_dec(CntH) : CntH;
      count_zero = (CntH == 8'h00) && (CntM == 8'h00) && (CntS == 8'h00);
      dec_zero   = (dec_h == 8'h00) && (dec_m == 8'h00) && (dec_s == 8'h00);
   end

   // Timer FSM: priority Stop > Load > Start > Tick, with all outputs registered here.
   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         state    <= S_IDLE;
         CntH     <= 8'h00;
         CntM     <= 8'h00;
         CntS     <= 8'h00;
         ring_cnt <= '0;
         Running  <= 1'b0;
         Done     <= 1'b0;
         Ring     <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_IDLE, S_PAUSE: begin
               if (Stop) begin
                  state <= S_IDLE;
               end else if (Load) begin
                  // A load wins over a simultaneous Start; the state is left alone.
                  CntH <= chk_h(LdH);
                  CntM <= chk_ms(LdM);
                  CntS <= chk_ms(LdS);
               end else if (Start && !count_zero) begin
                  state   <= S_RUN;
                  Running <= 1'b1;
               end
            end
            S_RUN: begin
               if (Stop) begin
                  state   <= S_PAUSE;
                  Running <= 1'b0;
               end else if (Tick) begin
                  CntH <= dec_h;
                  CntM <= dec_m;
                  CntS <= dec_s;
                  if (dec_zero) begin
                     state    <= S_RING;
                     Running  <= 1'b0;
                     Done     <= 1'b1;
                     Ring     <= 1'b1;
                     ring_cnt <= '0;
                  end
               end
            end
            S_RING: begin
               if (Stop) begin
                  state <= S_IDLE;
                  Ring  <= 1'b0;
               end else if (Tick) begin
                  if (ring_cnt == RING_LAST) begin
                     state    <= S_IDLE;
                     Ring     <= 1'b0;
                     ring_cnt <= '0;
                  end else begin
                     ring_cnt <= ring_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state   <= S_IDLE;
               Running <= 1'b0;
               Ring    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_hms.sv
// Bench for countdown_hms: directed steps followed by random stimulus.
// The reference keeps the count as a plain number of seconds.
// Outputs are compared 1 ns after each rising edge.
module tb_countdown_hms;

   localparam int HOUR_MAX   = 23;
   localparam int RING_TICKS = 10;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_RING  = 3;

   logic       CP = 1'b0;
   logic       nCR = 1'b0;
   logic       Tick = 1'b0, Load = 1'b0, Start = 1'b0, Stop = 1'b0;
   logic [7:0] LdH = 8'h00, LdM = 8'h00, LdS = 8'h00;
   logic [7:0] CntH, CntM, CntS;
   logic       Running, Done, Ring;

   int checks = 0;
   int failures = 0;

   int m_state = M_IDLE;
   int m_secs  = 0;
   int m_rc    = 0;
   bit m_done  = 1'b0;

   countdown_hms #(.HOUR_MAX(HOUR_MAX), .RING_TICKS(RING_TICKS)) dut (
      .CP(CP), .nCR(nCR), .Tick(Tick), .Load(Load),
      .LdH(LdH), .LdM(LdM), .LdS(LdS),
      .Start(Start), .Stop(Stop),
      .CntH(CntH), .CntM(CntM), .CntS(CntS),
      .Running(Running), .Done(Done), .Ring(Ring)
   );

   always #5 CP = ~CP;

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t, u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   function automatic int val_h(input logic [7:0] v);
      int t, u;
      t = int'(v[7:4]);
      u = int'(v[3:0]);
      if (t > 9 || u > 9 || t * 10 + u > HOUR_MAX) return 0;
      return t * 10 + u;
   endfunction

   function automatic int val_ms(input logic [7:0] v);
      int t, u;
      t = int'(v[7:4]);
      u = int'(v[3:0]);
      if (t > 5 || u > 9) return 0;
      return t * 10 + u;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference reaction to the inputs present at a rising edge.
   task automatic model_edge();
      m_done = 1'b0;
      case (m_state)
         M_IDLE, M_PAUSE: begin
            if (Stop) m_state = M_IDLE;
            else if (Load) m_secs = val_h(LdH) * 3600 + val_ms(LdM) * 60 + val_ms(LdS);
            else if (Start && m_secs > 0) m_state = M_RUN;
         end
         M_RUN: begin
            if (Stop) m_state = M_PAUSE;
            else if (Tick) begin
               m_secs--;
               if (m_secs == 0) begin
                  m_state = M_RING;
                  m_done  = 1'b1;
                  m_rc    = 0;
               end
            end
         end
         default: begin
            if (Stop) m_state = M_IDLE;
            else if (Tick) begin
               m_rc++;
               if (m_rc == RING_TICKS) m_state = M_IDLE;
            end
         end
      endcase
   endtask

   task automatic model_reset();
      m_state = M_IDLE;
      m_secs  = 0;
      m_rc    = 0;
      m_done  = 1'b0;
   endtask

   task automatic check_all(input string tag);
      logic [31:0] exp_cnt;
      exp_cnt = {8'h00, to_bcd(m_secs / 3600), to_bcd((m_secs / 60) % 60), to_bcd(m_secs % 60)};
      chk({tag, ".count"}, {8'h00, CntH, CntM, CntS}, exp_cnt);
      chk({tag, ".flags"}, {29'd0, Running, Done, Ring},
          {29'd0, m_state == M_RUN, m_done, m_state == M_RING});
   endtask

   // One clock: inputs already set, compare after the edge, then clear the pulses.
   task automatic cyc(input string tag);
      @(posedge CP);
      model_edge();
      #1;
      check_all(tag);
      Load = 1'b0; Start = 1'b0; Stop = 1'b0; Tick = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      LdH = h; LdM = m; LdS = s; Load = 1'b1;
      cyc("load");
   endtask

   task automatic do_start();
      Start = 1'b1;
      cyc("start");
   endtask

   task automatic do_stop();
      Stop = 1'b1;
      cyc("stop");
   endtask

   task automatic do_tick();
      Tick = 1'b1;
      cyc("tick");
      cyc("gap");
   endtask

   task automatic async_reset(input string tag);
      #2 nCR = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      #1 nCR = 1'b1;
   endtask

   initial begin
      logic [7:0] h, m, s;

      // Reset state, checked while nCR is still low.
      #2;
      check_all("reset");
      #1 nCR = 1'b1;

      // 00:00:03 counts down, pulses Done, rings for RING_TICKS ticks.
      do_load(8'h00, 8'h00, 8'h03);
      do_start();
      chk("run_flag", {31'd0, Running}, 32'd1);
      Tick = 1'b1; cyc("t1");
      chk("cnt_s_02", {24'd0, CntS}, 32'h02);
      cyc("gap");
      do_tick();
      chk("cnt_s_01", {24'd0, CntS}, 32'h01);
      Tick = 1'b1; cyc("t3");
      chk("done_pulse", {30'd0, Done, Ring}, 32'b11);
      cyc("after_done");
      chk("done_cleared", {30'd0, Done, Ring}, 32'b01);
      for (int i = 0; i < RING_TICKS - 1; i++) do_tick();
      chk("still_ringing", {31'd0, Ring}, 32'd1);
      do_tick();
      chk("ring_timeout", {30'd0, Ring, Running}, 32'd0);

      // Borrow through all three fields.
      do_load(8'h01, 8'h00, 8'h00);
      do_start();
      do_tick();
      chk("borrow_hms", {7'd0, Running, CntH, CntM, CntS}, {7'd0, 1'b1, 24'h00_59_59});
      do_stop();
      do_stop();

      // Stop with a coincident Tick pauses without decrementing.
      do_load(8'h00, 8'h10, 8'h00);
      do_start();
      do_tick();
      Stop = 1'b1; Tick = 1'b1; cyc("stop_tick");
      chk("pause_hold", {8'd0, CntH, CntM, CntS}, 32'h00_09_59);
      do_start();
      do_tick();
      chk("resume", {8'd0, CntH, CntM, CntS}, 32'h00_09_58);
      do_stop();
      do_stop();

      // Invalid fields load as zero; Start on zero count is ignored.
      do_load(8'h24, 8'h6A, 8'h30);
      chk("invalid_load", {8'd0, CntH, CntM, CntS}, 32'h00_00_30);
      do_load(8'h23, 8'h59, 8'h59);
      chk("max_load", {8'd0, CntH, CntM, CntS}, 32'h23_59_59);
      do_load(8'h00, 8'h00, 8'h00);
      do_start();
      chk("zero_start", {31'd0, Running}, 32'd0);

      // Load together with Start: load only, Start later.
      LdH = 8'h00; LdM = 8'h00; LdS = 8'h05; Load = 1'b1; Start = 1'b1;
      cyc("load_start");
      chk("load_start_idle", {31'd0, Running}, 32'd0);
      do_start();
      do_stop();
      do_stop();

      // Ring silenced by Stop; Load and Start ignored while ringing.
      do_load(8'h00, 8'h00, 8'h01);
      do_start();
      do_tick();
      LdH = 8'h00; LdM = 8'h00; LdS = 8'h07; Load = 1'b1; cyc("ring_load");
      do_start();
      chk("ring_ignores", {7'd0, Ring, CntH, CntM, CntS}, {7'd0, 1'b1, 24'h0});
      do_stop();
      chk("ring_stop", {31'd0, Ring}, 32'd0);

      // Asynchronous reset mid-run, then ticks have no effect.
      do_load(8'h20, 8'h00, 8'h00);
      do_start();
      do_tick();
      chk("h_borrow", {8'd0, CntH, CntM, CntS}, 32'h19_59_59);
      async_reset("async_reset");
      do_tick();
      do_tick();

      // Random traffic against the seconds-based reference.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            h = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
            m = ($urandom_range(0, 5) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 1));
            s = ($urandom_range(0, 4) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 12));
            LdH = h; LdM = m; LdS = s; Load = 1'b1;
         end
         Start = ($urandom_range(0, 5) == 0);
         Stop  = ($urandom_range(0, 40) == 0);
         Tick  = ($urandom_range(0, 2) == 0);
         cyc("rand");
         if ($urandom_range(0, 700) == 0) async_reset("rand_reset");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule
